// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit that drives a valid/ready data-memory bus and formats load data.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and raise Misalign_Err.
module mem_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MEM_Mem_r,
    input  logic                      MEM_Mem_w,
    input  logic [2:0]                MEM_Funct3,
    input  logic [BUS_ADDR_WIDTH-1:0] MEM_ALU_Result,
    input  logic [DATA_WIDTH-1:0]     MEM_Rs2_Data,
    output logic                      D_req,
    input  logic                      D_ready,
    output logic                      D_we,
    output logic [BUS_ADDR_WIDTH-1:0] D_addr,
    output logic [DATA_WIDTH-1:0]     D_wdata,
    output logic [3:0]                D_wstrb,
    input  logic [DATA_WIDTH-1:0]     D_rdata,
    input  logic                      D_rvalid,
    output logic [DATA_WIDTH-1:0]     MEM_Mem_R_Data,
    output logic                      Stall,
    output logic                      Misalign_Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      access_s;
    logic                      trap_s;
    logic                      stall_s;
    logic [1:0]                offs_s;
    logic [2:0]                funct3_r;
    logic [1:0]                offs_r;
    logic                      d_req_r;
    logic                      d_we_r;
    logic [BUS_ADDR_WIDTH-1:0] d_addr_r;
    logic [DATA_WIDTH-1:0]     d_wdata_r;
    logic [3:0]                d_wstrb_r;
    logic [DATA_WIDTH-1:0]     rdata_r;
    logic                      misalign_err_r;

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{rs2[7:0]}};
            2'b01:   lanes = {2{rs2[15:0]}};
            default: lanes = rs2;
        endcase
        return lanes;
    endfunction

    function automatic logic [3:0] store_strobes(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << offs;
            2'b01:   strb = 4'b0011 << {offs[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                                input logic [1:0]  offs,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (offs)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offs[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign access_s = MEM_Mem_r | MEM_Mem_w;

    // Byte offset actually used: misaligned half/word low bits are dropped.
    always_comb begin
        offs_s = MEM_ALU_Result[1:0];
        case (MEM_Funct3[1:0])
            2'b00:   offs_s = MEM_ALU_Result[1:0];
            2'b01:   offs_s = {MEM_ALU_Result[1], 1'b0};
            default: offs_s = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment detection on the raw address bits.
    always_comb begin
        trap_s = 1'b0;
        case (MEM_Funct3[1:0])
            2'b00:   trap_s = 1'b0;
            2'b01:   trap_s = MEM_ALU_Result[0];
            default: trap_s = (MEM_ALU_Result[1:0] != 2'b00);
        endcase
    end
`else
    assign trap_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    if (trap_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (D_ready) begin
                    state_nxt_s = d_we_r ? DONE : WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (D_rvalid) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pipeline freeze: held through the access, released in DONE, never during reset.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    stall_s = access_s;
                REQ:     stall_s = 1'b1;
                WAIT:    stall_s = 1'b1;
                default: stall_s = 1'b0;
            endcase
        end
    end

    // State register, request latch, bus fields and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            funct3_r       <= 3'd0;
            offs_r         <= 2'd0;
            d_req_r        <= 1'b0;
            d_we_r         <= 1'b0;
            d_addr_r       <= {BUS_ADDR_WIDTH{1'b0}};
            d_wdata_r      <= {DATA_WIDTH{1'b0}};
            d_wstrb_r      <= 4'd0;
            rdata_r        <= {DATA_WIDTH{1'b0}};
            misalign_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (access_s) begin
                        funct3_r       <= MEM_Funct3;
                        offs_r         <= offs_s;
                        d_addr_r       <= {MEM_ALU_Result[BUS_ADDR_WIDTH-1:2], 2'b00};
                        d_we_r         <= ~MEM_Mem_r;
                        d_wdata_r      <= MEM_Mem_r ? {DATA_WIDTH{1'b0}}
                                                    : store_lanes(MEM_Funct3[1:0], MEM_Rs2_Data);
                        d_wstrb_r      <= MEM_Mem_r ? 4'b0000
                                                    : store_strobes(MEM_Funct3[1:0], offs_s);
                        d_req_r        <= ~trap_s;
                        misalign_err_r <= trap_s;
                    end
                end
                REQ: begin
                    if (D_ready) begin
                        d_req_r <= 1'b0;
                    end
                end
                WAIT: begin
                    if (D_rvalid) begin
                        rdata_r <= load_format(funct3_r, offs_r, D_rdata);
                    end
                end
                DONE: begin
                    misalign_err_r <= 1'b0;
                end
                default: begin
                    d_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign D_req          = d_req_r;
    assign D_we           = d_we_r;
    assign D_addr         = d_addr_r;
    assign D_wdata        = d_wdata_r;
    assign D_wstrb        = d_wstrb_r;
    assign MEM_Mem_R_Data = rdata_r;
    assign Stall          = stall_s;
    assign Misalign_Err   = misalign_err_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: byte-array reference model, reactive memory responder, decoupled monitor.
`timescale 1ns/1ps
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Mem_r, MEM_Mem_w;
    logic [2:0]  MEM_Funct3;
    logic [31:0] MEM_ALU_Result, MEM_Rs2_Data;
    logic        D_req, D_ready, D_we, D_rvalid;
    logic [31:0] D_addr, D_wdata, D_rdata;
    logic [3:0]  D_wstrb;
    logic [31:0] MEM_Mem_R_Data;
    logic        Stall, Misalign_Err;

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .MEM_Mem_r(MEM_Mem_r), .MEM_Mem_w(MEM_Mem_w), .MEM_Funct3(MEM_Funct3),
        .MEM_ALU_Result(MEM_ALU_Result), .MEM_Rs2_Data(MEM_Rs2_Data),
        .D_req(D_req), .D_ready(D_ready), .D_we(D_we), .D_addr(D_addr),
        .D_wdata(D_wdata), .D_wstrb(D_wstrb), .D_rdata(D_rdata), .D_rvalid(D_rvalid),
        .MEM_Mem_R_Data(MEM_Mem_R_Data), .Stall(Stall), .Misalign_Err(Misalign_Err)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb; } req_t;
    typedef struct { logic [31:0] data; logic err; int stall; } res_t;

    req_t exp_req[$];
    res_t exp_res[$];

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ref_mem [1024];
    logic [31:0] ref_rdata = 32'd0;
    logic [31:0] resp_mem [256];
    int          ready_lat  = 0;
    int          rvalid_lat = 0;
    int          manual_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready after ready_lat REQ cycles, rvalid rvalid_lat cycles into WAIT.
    initial begin : responder
        logic        hs, hs_we, rst_s, rd_pend;
        logic [31:0] hs_addr, hs_wdata, rd_addr;
        logic [3:0]  hs_strb;
        int          rdy_cnt, rd_cnt, manual_seen;
        D_ready = 1'b0; D_rvalid = 1'b0; D_rdata = 32'd0;
        rdy_cnt = -1; rd_cnt = 0; rd_pend = 1'b0; rd_addr = 32'd0; manual_seen = 0;
        forever begin
            @(negedge clk);
            hs = D_req && D_ready; hs_we = D_we; hs_addr = D_addr;
            hs_wdata = D_wdata; hs_strb = D_wstrb; rst_s = rst;
            @(posedge clk); #1;
            D_rvalid = 1'b0;
            if (rst_s || rst) begin
                D_ready = 1'b0; rd_pend = 1'b0; rdy_cnt = -1;
            end else begin
                if (hs) begin
                    D_ready = 1'b0; rdy_cnt = -1;
                    if (hs_we) begin
                        for (int i = 0; i < 4; i++)
                            if (hs_strb[i]) resp_mem[hs_addr[9:2]][8*i +: 8] = hs_wdata[8*i +: 8];
                    end else begin
                        rd_pend = 1'b1; rd_cnt = rvalid_lat; rd_addr = hs_addr;
                    end
                end else if (D_req && !D_ready) begin
                    if (rdy_cnt < 0) rdy_cnt = ready_lat;
                    if (rdy_cnt == 0) D_ready = 1'b1;
                    else rdy_cnt--;
                end
                if (rd_pend) begin
                    if (rd_cnt == 0) begin
                        D_rvalid = 1'b1; D_rdata = resp_mem[rd_addr[9:2]]; rd_pend = 1'b0;
                    end else begin
                        rd_cnt--;
                    end
                end
            end
            if (manual_req != manual_seen) begin
                manual_seen = manual_req; D_rvalid = 1'b1; D_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    // Monitor: checks bus requests and completed accesses against the queues.
    initial begin : monitor
        logic held, hs_prev;
        int   stall_cnt;
        req_t h, e;
        res_t r;
        held = 1'b0; hs_prev = 1'b0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0; hs_prev = 1'b0; stall_cnt = 0;
            end else begin
                if (hs_prev) chk("req_drop_after_hs", D_req, 32'd0);
                hs_prev = 1'b0;
                if (D_req) begin
                    if (held) begin
                        chk("hold_addr", D_addr, h.addr);
                        chk("hold_we", D_we, h.we);
                        chk("hold_wdata", D_wdata, h.wdata);
                        chk("hold_wstrb", D_wstrb, h.strb);
                    end
                    h.addr = D_addr; h.we = D_we; h.wdata = D_wdata; h.strb = D_wstrb;
                    held = 1'b1;
                    if (D_ready) begin
                        held = 1'b0; hs_prev = 1'b1;
                        if (exp_req.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_req: got addr 0x%08h with no request expected", D_addr);
                        end else begin
                            e = exp_req.pop_front();
                            chk("req_addr", D_addr, e.addr);
                            chk("req_we", D_we, e.we);
                            if (e.we) begin
                                chk("req_wdata", D_wdata, e.wdata);
                                chk("req_wstrb", D_wstrb, e.strb);
                            end
                        end
                    end
                end else begin
                    held = 1'b0;
                end
                if ((MEM_Mem_r || MEM_Mem_w) && Stall) stall_cnt++;
                if ((MEM_Mem_r || MEM_Mem_w) && !Stall) begin
                    if (exp_res.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got completion with no access expected");
                    end else begin
                        r = exp_res.pop_front();
                        chk("load_data", MEM_Mem_R_Data, r.data);
                        chk("misalign_err", Misalign_Err, r.err);
                        chk("stall_cycles", stall_cnt, r.stall);
                    end
                    stall_cnt = 0;
                end else begin
                    chk("misalign_quiet", Misalign_Err, 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        MEM_Mem_r = 1'b0; MEM_Mem_w = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Reference model from the access rules, then drive and wait until the pipeline is released.
    task automatic do_txn(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input int rl, input int vl);
        int          bytes, n;
        logic        is_load, trap, sgn;
        logic [31:0] ea, val;
        logic [9:0]  bi;
        req_t        q;
        res_t        r;
        is_load = ld;
        bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        sgn   = !f3[2];
        trap  = TRAP_EN && ((addr % bytes) != 0);
        ea    = addr & ~(32'(bytes) - 32'd1);
        if (!trap) begin
            q.addr = addr & ~32'd3; q.we = !is_load;
            q.wdata = (bytes == 1) ? 32'(rs2[7:0]) * 32'h0101_0101 :
                      (bytes == 2) ? 32'(rs2[15:0]) * 32'h0001_0001 : rs2;
            q.strb  = (bytes == 1) ? 4'b0001 << addr[1:0] :
                      (bytes == 2) ? 4'b0011 << (addr[1:0] & 2'b10) : 4'b1111;
            exp_req.push_back(q);
            if (is_load) begin
                val = 32'd0;
                for (int i = 0; i < bytes; i++) begin
                    bi = ea[9:0] + 10'(i);
                    val = val | (32'(ref_mem[bi]) << (8 * i));
                end
                if (sgn && bytes < 4 && val[8*bytes-1]) val = val | (32'hFFFF_FFFF << (8 * bytes));
                ref_rdata = val;
            end else begin
                for (int i = 0; i < bytes; i++) begin
                    bi = ea[9:0] + 10'(i);
                    ref_mem[bi] = rs2[8*i +: 8];
                end
            end
        end
        r.data  = ref_rdata;
        r.err   = trap;
        r.stall = trap ? 1 : 1 + (rl + 1) + (is_load ? vl + 1 : 0);
        exp_res.push_back(r);
        ready_lat = rl; rvalid_lat = vl;
        MEM_Mem_r = ld; MEM_Mem_w = st; MEM_Funct3 = f3; MEM_ALU_Result = addr; MEM_Rs2_Data = rs2;
        n = 0;
        do begin @(negedge clk); n++; end while (Stall && n < 200);
        if (Stall) begin
            total++; bad++;
            $display("FAIL stall_timeout: Stall still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400us;
        $display("FAIL watchdog: simulation did not finish within 40000 cycles");
        $fatal(1);
    end

    initial begin : main
        req_t q;
        logic ld, st;
        for (int w = 0; w < 256; w++) begin
            resp_mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[w*4+b] = resp_mem[w][8*b +: 8];
        end
        rst = 1'b1;
        MEM_Mem_r = 1'b1; MEM_Mem_w = 1'b0; MEM_Funct3 = 3'b010;
        MEM_ALU_Result = 32'h0000_0100; MEM_Rs2_Data = 32'd0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", Stall, 32'd0);
            chk("rst_req", D_req, 32'd0);
            chk("rst_data", MEM_Mem_R_Data, 32'd0);
            chk("rst_err", Misalign_Err, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; MEM_Mem_r = 1'b0;
        idle(2);

        // Reset while waiting for read data; the late rvalid must be ignored.
        ready_lat = 0; rvalid_lat = 60;
        q.addr = 32'h0000_0040; q.we = 1'b0; q.wdata = 32'd0; q.strb = 4'd0;
        exp_req.push_back(q);
        MEM_Mem_r = 1'b1; MEM_Funct3 = 3'b010; MEM_ALU_Result = 32'h0000_0040;
        repeat (3) @(negedge clk);
        chk("wait_stall", Stall, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; MEM_Mem_r = 1'b0;
        @(negedge clk);
        chk("midrst_req", D_req, 32'd0);
        chk("midrst_stall", Stall, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; manual_req++;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_req", D_req, 32'd0);
            chk("postrst_stall", Stall, 32'd0);
            chk("postrst_data", MEM_Mem_R_Data, 32'd0);
        end
        @(posedge clk); #1;

        // Directed accesses.
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0);
        idle(1);
        do_txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h80FF_1234, 0, 0);
        idle(1);
        do_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 0);
        chk("lb_103", MEM_Mem_R_Data, 32'hFFFF_FF80);
        do_txn(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 0, 0);
        chk("lbu_103", MEM_Mem_R_Data, 32'h0000_0080);
        do_txn(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 0, 0);
        chk("lhu_102", MEM_Mem_R_Data, 32'h0000_80FF);
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 0);
        chk("lw_101", MEM_Mem_R_Data, TRAP_EN ? 32'h0000_80FF : 32'h80FF_1234);
        idle(1);
        do_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5, 0);
        idle(1);
        do_txn(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'd0, 0, 0);
        do_txn(1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h0000_005A, 0, 0);
        idle(1);
        do_txn(1'b1, 1'b1, 3'b000, 32'h0000_0005, 32'h1111_1111, 1, 2);

        // Randomized mix of sizes, directions, addresses and bus latencies.
        for (int k = 0; k < 250; k++) begin
            ld = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
            if (!ld && !st) ld = 1'b1;
            do_txn(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        chk("req_queue_empty", exp_req.size(), 32'd0);
        chk("res_queue_empty", exp_res.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
